// File: rtl/ads127l18_pkg.sv
// ads127l18_pkg -- shared constants and types for the ADS127L18 receiver.
//   ADS_LANE_COUNT      : default number of DOUT lanes
//   ADS_BITS_PER_PACKET : default bits per lane per frame
//   rx_state_t          : frame capture FSM encoding
package ads127l18_pkg;
  localparam int ADS_LANE_COUNT      = 8;
  localparam int ADS_BITS_PER_PACKET = 24;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    WAIT_SYNC = 2'd2
  } rx_state_t;
endpackage

// File: rtl/ads127l18_lane_shift.sv
// ads127l18_lane_shift -- MSB-first shift register for one DOUT lane.
//   clk, rst : system clock, synchronous active-high reset
//   i_load   : start a new word; clears older bits, i_bit becomes bit 0
//   i_shift  : shift left one place, inserting i_bit at bit 0
//   i_bit    : synchronized lane bit sampled on the current dclk edge
//   o_word   : current word contents
module ads127l18_lane_shift #(
  parameter int BITS = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_shift,
  input  logic            i_bit,
  output logic [BITS-1:0] o_word
);
  logic [BITS-1:0] r_word;

  always_ff @(posedge clk) begin
    if (rst)          r_word <= '0;
    else if (i_load)  r_word <= {{(BITS-1){1'b0}}, i_bit};
    else if (i_shift) r_word <= {r_word[BITS-2:0], i_bit};
  end

  assign o_word = r_word;
endmodule

// File: rtl/sync_signal.sv
// sync_signal -- multi-flop synchronizer for asynchronous pin inputs.
//   clk : destination clock
//   rst : synchronous active-high reset, clears every stage
//   i_d : asynchronous input vector (each bit is independent)
//   o_q : synchronized output, STAGES clk cycles late
module sync_signal #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [STAGES-1:0][WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int s = 1; s < STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/ads127l18_rx.sv
// ads127l18_rx -- ADS127L18 multi-lane frame receiver with AXI-Stream-style output.
//   clk         : 125 MHz system clock (only clock used)
//   rst         : synchronous active-high reset
//   fsync, dclk : asynchronous ADC frame-sync / data-clock pins
//   dout        : asynchronous ADC data pins, bit i = lane i
//   m_tdata     : frame word, lane i at [i*BITS_PER_PACKET +: BITS_PER_PACKET]
//   m_tvalid    : frame word valid; m_tready : downstream accept
//   data_ready  : one-cycle pulse per completed frame
//   overflow    : one-cycle pulse when a completed frame is dropped
//   frame_err   : one-cycle pulse when fsync restarts a frame mid-capture
//   m_frame_cnt : completed-frame count, present only with ADS127L18_RX_FRAME_CNT_EN
module ads127l18_rx
  import ads127l18_pkg::*;
#(
  parameter int LANE_COUNT      = ADS_LANE_COUNT,
  parameter int BITS_PER_PACKET = ADS_BITS_PER_PACKET,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  fsync,
  input  logic                                  dclk,
  input  logic [LANE_COUNT-1:0]                 dout,
  output logic [LANE_COUNT*BITS_PER_PACKET-1:0] m_tdata,
  output logic                                  m_tvalid,
  input  logic                                  m_tready,
  output logic                                  data_ready,
  output logic                                  overflow,
  output logic                                  frame_err
`ifdef ADS127L18_RX_FRAME_CNT_EN
  ,
  output logic [15:0]                           m_frame_cnt
`endif
);
  localparam int CW = $clog2(BITS_PER_PACKET + 1);

  // Pin synchronization: {fsync, dclk, dout} through SYNC_STAGES flops
  logic [LANE_COUNT+1:0] w_sync;
  logic                  w_fsync_s, w_dclk_s;
  logic [LANE_COUNT-1:0] w_dout_s;

  sync_signal #(.WIDTH(LANE_COUNT + 2), .STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d ({fsync, dclk, dout}),
    .o_q (w_sync)
  );

  assign w_fsync_s = w_sync[LANE_COUNT+1];
  assign w_dclk_s  = w_sync[LANE_COUNT];
  assign w_dout_s  = w_sync[LANE_COUNT-1:0];

  rx_state_t r_state;
  logic [CW-1:0] r_bit_cnt;
  logic r_dclk_prev, r_fsync_prev;
  logic r_done, r_frame_err;

  logic w_edge, w_start, w_shift;
  assign w_edge  = w_dclk_s & ~r_dclk_prev;
  assign w_start = w_edge & w_fsync_s & ~r_fsync_prev;
  // A start always reloads the lanes, so a restart in SHIFT discards the partial word
  assign w_shift = w_edge & ~w_start & (r_state == SHIFT);

  logic [LANE_COUNT-1:0][BITS_PER_PACKET-1:0] w_lane_word;

  for (genvar g = 0; g < LANE_COUNT; g++) begin : g_lane
    ads127l18_lane_shift #(.BITS(BITS_PER_PACKET)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_start),
      .i_shift (w_shift),
      .i_bit   (w_dout_s[g]),
      .o_word  (w_lane_word[g])
    );
  end

  // Frame capture FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_dclk_prev  <= 1'b0;
      r_fsync_prev <= 1'b0;
      r_done       <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_dclk_prev <= w_dclk_s;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_edge) begin
        r_fsync_prev <= w_fsync_s;
        case (r_state)
          IDLE, WAIT_SYNC: begin
            if (w_start) begin
              r_bit_cnt <= CW'(1);
              r_state   <= SHIFT;
            end
          end
          SHIFT: begin
            if (w_start) begin
              r_frame_err <= 1'b1;
              r_bit_cnt   <= CW'(1);
            end else begin
              r_bit_cnt <= r_bit_cnt + CW'(1);
              if (r_bit_cnt == CW'(BITS_PER_PACKET - 1)) begin
                r_done  <= 1'b1;
                r_state <= WAIT_SYNC;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Output stage: the completed word sits in the lanes during the r_done cycle
  // (dclk edges are at least four clk cycles apart), so load it from there.
  logic [LANE_COUNT*BITS_PER_PACKET-1:0] r_tdata;
  logic r_tvalid, r_overflow;
  logic w_can_load;
  assign w_can_load = ~r_tvalid | m_tready;

`ifdef ADS127L18_RX_FRAME_CNT_EN
  logic [15:0] r_frame_cnt, r_frame_cnt_out;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt     <= '0;
      r_frame_cnt_out <= '0;
    end else if (r_done) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_can_load) r_frame_cnt_out <= r_frame_cnt + 16'd1;
    end
  end
  assign m_frame_cnt = r_frame_cnt_out;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (r_done && w_can_load) begin
        r_tdata  <= w_lane_word;
        r_tvalid <= 1'b1;
      end else begin
        if (m_tready) r_tvalid <= 1'b0;
        if (r_done)   r_overflow <= 1'b1;
      end
    end
  end

  assign m_tdata    = r_tdata;
  assign m_tvalid   = r_tvalid;
  assign data_ready = r_done;
  assign overflow   = r_overflow;
  assign frame_err  = r_frame_err;
endmodule
